// File: rtl/iob_cpu_bridge_pkg.sv
// Shared types and helpers for the CPU-bus to IOb bridge: FSM encoding,
// lane-width constants and byte-strobe generation.
package iob_cpu_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Constants for the default 32-bit build; the bridge derives its own from DATA_W.
  localparam int DATA_W_DFLT = 32;
  localparam int STRB_W      = DATA_W_DFLT / 8;
  localparam int LANE_W      = $clog2(STRB_W);

  // Widest supported bus is 64 bits, so strobes never exceed 8 lanes.
  localparam int MAX_STRB_W  = 8;

  // Byte strobe for a lane-aligned access; oversize accesses become full-word.
  function automatic logic [MAX_STRB_W-1:0] gen_strb(
    input logic       wr,
    input logic [1:0] size,
    input logic [2:0] addr_lo,
    input int         lane_w
  );
    int sz;
    int off;
    int mask;
    int sh;
    if (!wr) return '0;
    sz = int'(size);
    if (sz > lane_w) return '1;
    off  = int'(addr_lo) & ((1 << lane_w) - 1);
    mask = (1 << (1 << sz)) - 1;
    sh   = mask << off;
    return sh[MAX_STRB_W-1:0];
  endfunction

endpackage

// File: rtl/iob_cpu_bridge_wdog.sv
// Bus watchdog: counts stalled busy cycles and flags the cycle in which the
// count reaches 2^CNT_W-1.
module iob_cpu_bridge_wdog #(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = ~CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // This stalled cycle is the one that brings the count to its terminal value.
  assign tc_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/iob_cpu_bus_bridge.sv
// CPU valid/ready command bus to IOb native bus bridge with a one-entry request
// stage and watchdog. Optional boot remap: IOB_CPU_BRIDGE_EXTMEM_REMAP_EN.
module iob_cpu_bus_bridge
  import iob_cpu_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int WR_RSP    = 0,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [1:0]          cmd_size,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_error,
  output logic                iob_valid,
  output logic [ADDR_W-1:0]   iob_addr,
  output logic [DATA_W-1:0]   iob_wdata,
  output logic [DATA_W/8-1:0] iob_wstrb,
  input  logic [DATA_W-1:0]   iob_rdata,
  input  logic                iob_ready,
  input  logic                boot
);

  localparam int   BR_STRB_W = DATA_W / 8;
  localparam int   BR_LANE_W = $clog2(BR_STRB_W);
  localparam logic WR_RSP_B  = (WR_RSP != 0);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [BR_STRB_W-1:0]   strb_q, strb_d;
  logic                   pend_wr_q, pend_wr_d;

  logic                   busy;
  logic                   accept;
  logic                   tmo;
  logic [MAX_STRB_W-1:0]  strb_full;
  logic [ADDR_W-1:0]      addr_map;

  assign busy      = (state_q == BUSY);
  // A completing transaction frees the stage in the same cycle.
  assign cmd_ready = ~busy | iob_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign strb_full = gen_strb(cmd_wr, cmd_size, cmd_addr[2:0], BR_LANE_W);

`ifdef IOB_CPU_BRIDGE_EXTMEM_REMAP_EN
  // After boot the top address bit is flipped so the image runs from external memory.
  assign addr_map = {cmd_addr[ADDR_W-1] ^ ~boot, cmd_addr[ADDR_W-2:0]};
`else
  logic unused_boot;
  assign unused_boot = boot;
  assign addr_map    = cmd_addr;
`endif

  generate
    if (TIMEOUT_W > 0) begin : g_wdog
      iob_cpu_bridge_wdog #(
        .CNT_W(TIMEOUT_W)
      ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (busy & ~iob_ready),
        .tc_o  (tmo)
      );
    end else begin : g_no_wdog
      assign tmo = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pend_wr_d = pend_wr_q;
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    rsp_data  = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = BUSY;
      end
      BUSY: begin
        // iob_ready takes priority over a watchdog expiry in the same cycle.
        if (iob_ready) begin
          rsp_valid = pend_wr_q ? WR_RSP_B : 1'b1;
          rsp_data  = pend_wr_q ? '0 : iob_rdata;
          state_d   = cmd_valid ? BUSY : IDLE;
        end else if (tmo) begin
          rsp_valid = 1'b1;
          rsp_error = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      addr_d    = addr_map;
      wdata_d   = cmd_wdata;
      strb_d    = strb_full[BR_STRB_W-1:0];
      pend_wr_d = cmd_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign iob_valid = busy;
  assign iob_addr  = addr_q;
  assign iob_wdata = wdata_q;
  assign iob_wstrb = strb_q;

endmodule

// File: tb/tb_iob_cpu_bus_bridge.sv
// Bench for iob_cpu_bus_bridge: directed scenarios on a 32-bit/TIMEOUT_W=4 and a
// 64-bit/WR_RSP=1 instance, plus randomized traffic against a transaction model.
module tb_iob_cpu_bus_bridge;

  localparam int WR_RSP0 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic boot = 1'b1;
  always #5 clk = ~clk;

  logic        c0_valid, c0_ready, c0_wr;
  logic [31:0] c0_addr, c0_wdata;
  logic [1:0]  c0_size;
  logic        r0_valid, r0_err;
  logic [31:0] r0_data;
  logic        i0_valid;
  logic [31:0] i0_addr, i0_wdata;
  logic [3:0]  i0_wstrb;
  logic [31:0] m0_rdata;
  logic        m0_ready;

  logic        c1_valid, c1_ready, c1_wr;
  logic [31:0] c1_addr;
  logic [63:0] c1_wdata;
  logic [1:0]  c1_size;
  logic        r1_valid, r1_err;
  logic [63:0] r1_data;
  logic        i1_valid;
  logic [31:0] i1_addr;
  logic [63:0] i1_wdata;
  logic [7:0]  i1_wstrb;
  logic [63:0] m1_rdata;
  logic        m1_ready;

  int n_checks = 0;
  int n_pass   = 0;

  iob_cpu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .WR_RSP(WR_RSP0), .TIMEOUT_W(4)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_wr(c0_wr),
    .cmd_addr(c0_addr), .cmd_wdata(c0_wdata), .cmd_size(c0_size), .rsp_valid(r0_valid),
    .rsp_data(r0_data), .rsp_error(r0_err), .iob_valid(i0_valid), .iob_addr(i0_addr),
    .iob_wdata(i0_wdata), .iob_wstrb(i0_wstrb), .iob_rdata(m0_rdata), .iob_ready(m0_ready),
    .boot(boot)
  );

  iob_cpu_bus_bridge #(.ADDR_W(32), .DATA_W(64), .WR_RSP(1), .TIMEOUT_W(0)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_wr(c1_wr),
    .cmd_addr(c1_addr), .cmd_wdata(c1_wdata), .cmd_size(c1_size), .rsp_valid(r1_valid),
    .rsp_data(r1_data), .rsp_error(r1_err), .iob_valid(i1_valid), .iob_addr(i1_addr),
    .iob_wdata(i1_wdata), .iob_wstrb(i1_wstrb), .iob_rdata(m1_rdata), .iob_ready(m1_ready),
    .boot(boot)
  );

  // Byte-lane model: bytes [off, off+2^size) of the word, or all lanes if oversize.
  function automatic logic [7:0] ref_strb(input logic wr, input int size, input logic [31:0] addr,
                                          input int lanes);
    logic [7:0] s;
    int nb, off;
    s = '0;
    if (!wr) return s;
    nb  = 1 << size;
    off = int'(addr % lanes);
    for (int i = 0; i < lanes; i++)
      if (nb > lanes || (i >= off && i < off + nb)) s[i] = 1'b1;
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({i0_valid, i0_addr, i0_wdata, i0_wstrb} !== '0)
      $display("FAIL reset_iob0 got v=%0b a=%h d=%h s=%h want all 0", i0_valid, i0_addr, i0_wdata, i0_wstrb);
    else n_pass++;
    n_checks++;
    if ({r0_valid, r0_err, r0_data} !== '0)
      $display("FAIL reset_rsp0 got v=%0b e=%0b d=%h want all 0", r0_valid, r0_err, r0_data);
    else n_pass++;
    n_checks++;
    if (c0_ready !== 1'b1) $display("FAIL reset_cmd_ready got %0b want 1", c0_ready);
    else n_pass++;
    n_checks++;
    if ({i1_valid, i1_wstrb, r1_valid, r1_data} !== '0)
      $display("FAIL reset_u1 got v=%0b s=%h rv=%0b rd=%h want 0", i1_valid, i1_wstrb, r1_valid, r1_data);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    c0_valid = 1; c0_wr = 0; c0_addr = 32'h104; c0_size = 2; c0_wdata = 0;
    step();
    c0_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (i0_valid !== 1'b1 || i0_addr !== 32'h104 || i0_wstrb !== 4'h0)
          $display("FAIL read_issue got v=%0b a=%h s=%h want 1/00000104/0", i0_valid, i0_addr, i0_wstrb);
        else n_pass++;
      end
      n_checks++;
      if (r0_valid !== 1'b0) $display("FAIL read_wait_rsp got %0b want 0 (cycle %0d)", r0_valid, k);
      else n_pass++;
      step();
    end
    m0_ready = 1; m0_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (r0_valid !== 1'b1 || r0_data !== 32'hDEADBEEF || r0_err !== 1'b0)
      $display("FAIL read_rsp got v=%0b d=%h e=%0b want 1/deadbeef/0", r0_valid, r0_data, r0_err);
    else n_pass++;
    step();
    m0_ready = 0;
    @(negedge clk);
    n_checks++;
    if (r0_valid !== 1'b0 || i0_valid !== 1'b0)
      $display("FAIL read_after got rv=%0b iv=%0b want 0/0", r0_valid, i0_valid);
    else n_pass++;
    step();
  endtask

  task automatic u1_txn(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                        output logic [7:0] strb, output int rsps, output logic vld_after);
    c1_valid = 1; c1_wr = wr; c1_addr = addr; c1_size = size;
    c1_wdata = {$urandom, $urandom}; m1_rdata = {$urandom, $urandom};
    step();
    c1_valid = 0; rsps = 0;
    @(negedge clk);
    strb = i1_wstrb;
    if (r1_valid) rsps++;
    step();
    m1_ready = 1;
    @(negedge clk);
    if (r1_valid) rsps++;
    step();
    m1_ready = 0;
    @(negedge clk);
    if (r1_valid) rsps++;
    vld_after = i1_valid;
    step();
  endtask

  task automatic test_byte_write();
    logic [7:0] s;
    int rsps;
    logic va;
    c0_valid = 1; c0_wr = 1; c0_addr = 32'h203; c0_size = 0; c0_wdata = 32'h11223344;
    step();
    c0_valid = 0;
    @(negedge clk);
    n_checks++;
    if (i0_valid !== 1'b1 || i0_wstrb !== 4'h8 || i0_wdata !== 32'h11223344)
      $display("FAIL bytewr_issue got v=%0b s=%h d=%h want 1/8/11223344", i0_valid, i0_wstrb, i0_wdata);
    else n_pass++;
    step();
    m0_ready = 1;
    @(negedge clk);
    n_checks++;
    if (r0_valid !== 1'b0) $display("FAIL bytewr_silent got rsp_valid=%0b want 0", r0_valid);
    else n_pass++;
    step();
    m0_ready = 0;
    @(negedge clk);
    n_checks++;
    if (i0_valid !== 1'b0 || r0_valid !== 1'b0)
      $display("FAIL bytewr_done got iv=%0b rv=%0b want 0/0", i0_valid, r0_valid);
    else n_pass++;
    step();
    u1_txn(32'h203, 2'd0, 1'b1, s, rsps, va);
    n_checks++;
    if (s !== 8'h08 || rsps !== 1 || va !== 1'b0)
      $display("FAIL bytewr_wrrsp got s=%h rsps=%0d v=%0b want 08/1/0", s, rsps, va);
    else n_pass++;
  endtask

  task automatic test_strobe64();
    logic [7:0] s;
    int rsps;
    logic va;
    u1_txn(32'h6, 2'd1, 1'b1, s, rsps, va);
    n_checks++;
    if (s !== 8'hC0 || rsps !== 1) $display("FAIL strb64_half got s=%h rsps=%0d want c0/1", s, rsps);
    else n_pass++;
    u1_txn(32'h0, 2'd3, 1'b1, s, rsps, va);
    n_checks++;
    if (s !== 8'hFF || rsps !== 1) $display("FAIL strb64_dword got s=%h rsps=%0d want ff/1", s, rsps);
    else n_pass++;
    u1_txn(32'h8, 2'd3, 1'b0, s, rsps, va);
    n_checks++;
    if (s !== 8'h00 || rsps !== 1) $display("FAIL strb64_read got s=%h rsps=%0d want 00/1", s, rsps);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    int rsps;
    int drops;
    a[0] = 32'h1000; a[1] = 32'h2004; a[2] = 32'h3008; a[3] = 32'h400C;
    rsps = 0; drops = 0;
    c0_valid = 1; c0_wr = 0; c0_size = 2; c0_addr = a[0];
    step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) c0_addr = a[k+1];
      else       c0_valid = 0;
      m0_ready = 0;
      @(negedge clk);
      if (i0_valid !== 1'b1) drops++;
      n_checks++;
      if (i0_addr !== a[k]) $display("FAIL b2b_addr got %h want %h", i0_addr, a[k]);
      else n_pass++;
      step();
      m0_ready = 1; m0_rdata = 32'hA000 + k;
      @(negedge clk);
      if (i0_valid !== 1'b1) drops++;
      if (r0_valid === 1'b1) rsps++;
      n_checks++;
      if (r0_data !== 32'hA000 + k) $display("FAIL b2b_data got %h want %h", r0_data, 32'hA000 + k);
      else n_pass++;
      step();
    end
    m0_ready = 0;
    @(negedge clk);
    n_checks++;
    if (drops !== 0 || rsps !== 4 || i0_valid !== 1'b0)
      $display("FAIL b2b_summary got drops=%0d rsps=%0d final_v=%0b want 0/4/0", drops, rsps, i0_valid);
    else n_pass++;
    step();
  endtask

  task automatic test_timeout();
    int busy_n;
    bit hit;
    busy_n = 0; hit = 0;
    c0_valid = 1; c0_wr = 0; c0_addr = 32'h40; c0_size = 2; m0_ready = 0;
    step();
    c0_valid = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (i0_valid === 1'b1) busy_n++;
      if (r0_valid === 1'b1) begin
        hit = 1;
        n_checks++;
        if (r0_err !== 1'b1 || r0_data !== 32'h0)
          $display("FAIL tmo_rsp got e=%0b d=%h want 1/0", r0_err, r0_data);
        else n_pass++;
      end
      step();
    end
    n_checks++;
    if (!hit || busy_n !== 15) $display("FAIL tmo_cycles got hit=%0b busy=%0d want 1/15", hit, busy_n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (i0_valid !== 1'b0 || r0_valid !== 1'b0)
      $display("FAIL tmo_after got iv=%0b rv=%0b want 0/0", i0_valid, r0_valid);
    else n_pass++;
    step();
    c0_valid = 1; c0_addr = 32'h44;
    step();
    c0_valid = 0; m0_ready = 1; m0_rdata = 32'h5A5A1234;
    @(negedge clk);
    n_checks++;
    if (r0_valid !== 1'b1 || r0_err !== 1'b0 || r0_data !== 32'h5A5A1234)
      $display("FAIL tmo_recover got v=%0b e=%0b d=%h want 1/0/5a5a1234", r0_valid, r0_err, r0_data);
    else n_pass++;
    step();
    m0_ready = 0;
    step();
  endtask

  task automatic test_reset_mid();
    c0_valid = 1; c0_wr = 1; c0_addr = 32'h300; c0_size = 2; c0_wdata = 32'hCAFEF00D;
    step();
    c0_valid = 0;
    @(negedge clk);
    n_checks++;
    if (i0_valid !== 1'b1) $display("FAIL rstmid_busy got %0b want 1", i0_valid);
    else n_pass++;
    rst = 1; m0_ready = 1;
    #1;
    n_checks++;
    if ({i0_valid, i0_addr, i0_wdata, i0_wstrb, r0_valid, r0_err, r0_data} !== '0)
      $display("FAIL rstmid_outputs got iv=%0b a=%h d=%h s=%h rv=%0b want all 0",
               i0_valid, i0_addr, i0_wdata, i0_wstrb, r0_valid);
    else n_pass++;
    step();
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (r0_valid !== 1'b0) $display("FAIL idle_ready_ignored got rsp_valid=%0b want 0", r0_valid);
    else n_pass++;
    m0_ready = 0;
    step();
  endtask

`ifdef IOB_CPU_BRIDGE_EXTMEM_REMAP_EN
  task automatic test_remap();
    logic [31:0] want;
    for (int b = 1; b >= 0; b--) begin
      boot = b[0];
      want = b ? 32'h00000010 : 32'h80000010;
      c0_valid = 1; c0_wr = 0; c0_addr = 32'h10; c0_size = 2;
      step();
      c0_valid = 0;
      @(negedge clk);
      n_checks++;
      if (i0_addr !== want) $display("FAIL remap_boot%0d got %h want %h", b, i0_addr, want);
      else n_pass++;
      step();
      m0_ready = 1;
      step();
      m0_ready = 0;
    end
    boot = 1;
  endtask
`endif

  task automatic test_random();
    bit busy, hold, acc, exp_rdy, exp_rv;
    logic        cur_wr;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_strb;
    logic [31:0] exp_rd;
    int bcyc, lat, errs;
    busy = 0; hold = 0; bcyc = 0; lat = 0; errs = 0;
    cur_wr = 0; cur_addr = 0; cur_wdata = 0; cur_strb = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!hold) begin
        if ($urandom_range(0, 3) != 0) begin
          c0_valid = 1; c0_wr = $urandom_range(0, 1); c0_size = 2'($urandom_range(0, 3));
          c0_addr = $urandom; c0_wdata = $urandom; hold = 1;
        end else c0_valid = 0;
      end
      m0_ready = busy && (bcyc == lat);
      m0_rdata = $urandom;
      @(negedge clk);
      exp_rdy = !busy || m0_ready;
      exp_rv  = busy && m0_ready && (!cur_wr || WR_RSP0 != 0);
      exp_rd  = (busy && m0_ready && !cur_wr) ? m0_rdata : 32'h0;
      n_checks++;
      if (c0_ready !== exp_rdy || i0_valid !== busy) begin
        errs++;
        if (errs < 10) $display("FAIL rnd_ctrl cyc %0d got rdy=%0b v=%0b want %0b/%0b", cyc, c0_ready, i0_valid, exp_rdy, busy);
      end else n_pass++;
      n_checks++;
      if (busy && (i0_addr !== cur_addr || i0_wstrb !== cur_strb || i0_wdata !== cur_wdata)) begin
        errs++;
        if (errs < 10) $display("FAIL rnd_req cyc %0d got a=%h s=%h d=%h want %h/%h/%h", cyc,
                                i0_addr, i0_wstrb, i0_wdata, cur_addr, cur_strb, cur_wdata);
      end else n_pass++;
      n_checks++;
      if (r0_valid !== exp_rv || r0_data !== exp_rd || r0_err !== 1'b0) begin
        errs++;
        if (errs < 10) $display("FAIL rnd_rsp cyc %0d got v=%0b d=%h e=%0b want %0b/%h/0", cyc,
                                r0_valid, r0_data, r0_err, exp_rv, exp_rd);
      end else n_pass++;
      acc = c0_valid && exp_rdy;
      if (busy && m0_ready) busy = 0;
      else if (busy) bcyc++;
      if (acc) begin
        busy = 1; bcyc = 0; lat = $urandom_range(0, 4); hold = 0;
        cur_wr = c0_wr; cur_addr = c0_addr; cur_wdata = c0_wdata;
        cur_strb = ref_strb(c0_wr, int'(c0_size), c0_addr, 4)[3:0];
      end
      step();
    end
    c0_valid = 0; m0_ready = 0;
    for (int k = 0; k < 8; k++) begin
      m0_ready = i0_valid;
      step();
    end
    m0_ready = 0;
  endtask

  initial begin
    c0_valid = 0; c0_wr = 0; c0_addr = 0; c0_wdata = 0; c0_size = 0; m0_rdata = 0; m0_ready = 0;
    c1_valid = 0; c1_wr = 0; c1_addr = 0; c1_wdata = 0; c1_size = 0; m1_rdata = 0; m1_ready = 0;
    test_reset();
    test_read();
    test_byte_write();
    test_strobe64();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef IOB_CPU_BRIDGE_EXTMEM_REMAP_EN
    test_remap();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iob_cpu_bus_bridge.md
Name: iob_cpu_bus_bridge

Overview:
- Parametrised bridge from a CPU valid/ready command bus plus response bus (VexRiscv-style iBus/dBus) to the IOb native bus (valid/addr/wdata/wstrb → rdata/ready).
- Successor to the fixed 32-bit per-core glue. Adds:
  - configurable data width and strobe generation
  - one-entry registered command stage with back-to-back issue
  - selectable write-response policy
  - bus-timeout watchdog with error response
- One instance per CPU bus (instruction and data), placed between the core and the system interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; 32 or 64.
- WR_RSP, 0, 1 = writes also produce rsp_valid; 0 = writes are silent.
- TIMEOUT_W, 8, watchdog counter width; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  CPU command valid
- cmd_ready  out  1  command accepted this cycle
- cmd_wr  in  1  1 = write
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data, already lane-aligned
- cmd_size  in  2  log2 of access bytes
- rsp_valid  out  1  response strobe, one cycle
- rsp_data  out  DATA_W  read data
- rsp_error  out  1  valid with rsp_valid; 1 = timeout
- iob_valid  out  1  IOb request valid
- iob_addr  out  ADDR_W  IOb address
- iob_wdata  out  DATA_W  IOb write data
- iob_wstrb  out  DATA_W/8  byte strobes; all 0 = read
- iob_rdata  in  DATA_W  IOb read data
- iob_ready  in  1  IOb transaction done, one-cycle pulse
- boot  in  1  boot status; used only by the optional feature

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values: iob_valid=0, iob_addr=0, iob_wdata=0, iob_wstrb=0, rsp_valid=0, rsp_error=0, rsp_data=0, state=IDLE, timeout counter=0.
- FSM states:
  - IDLE: cmd_ready=1.
  - BUSY: cmd_ready=iob_ready (completion cycle frees the stage).
- Accept = cmd_valid & cmd_ready. On accept, the request register loads addr, wdata, strobe and a pending_wr bit. State goes to or stays in BUSY.
- iob_valid is registered: it rises the cycle after accept. Minimum command-to-iob latency is 1 cycle.
- iob_valid stays high with stable addr/wdata/wstrb until iob_ready or timeout.
- Strobe:
  - cmd_wr=0 → 0.
  - Otherwise ((1<<(1<<cmd_size))-1) << cmd_addr[log2(DATA_W/8)-1:0], truncated to DATA_W/8 bits.
  - cmd_size above log2(DATA_W/8) is saturated to a full-word strobe.
- Completion (iob_ready in BUSY):
  - Read: rsp_valid=1 and rsp_data=iob_rdata in the same cycle (combinational pass-through), rsp_error=0.
  - Write: rsp_valid=WR_RSP.
- Simultaneous iob_ready and a new cmd_valid:
  - The new command is accepted and iob_valid stays 1 in the next cycle with the new request.
  - Zero bubble: back-to-back throughput is 1 transaction per IOb completion.
- Completion without a new command: next state IDLE, iob_valid drops next cycle.
- iob_ready while IDLE is ignored (no rsp_valid).
- Watchdog (TIMEOUT_W>0):
  - Counter clears on accept and counts each BUSY cycle without iob_ready.
  - On reaching 2^TIMEOUT_W-1:
    - iob_valid drops, state goes to IDLE.
    - rsp_valid=1 and rsp_error=1 for one cycle, regardless of read/write and WR_RSP; rsp_data=0.
  - iob_ready in the same cycle as terminal count wins: normal completion.
- rst mid-transaction aborts immediately. No response is generated.

Optional Feature:
- Macro IOB_CPU_BRIDGE_EXTMEM_REMAP_EN.
- With it defined:
  - iob_addr[ADDR_W-1] = cmd_addr[ADDR_W-1] ^ ~boot, captured at accept.
  - Lets the same firmware image run from SRAM while booting and from external memory afterwards.
- Without it: iob_addr = cmd_addr unchanged, and boot is unused.

Decomposition:
- Shared package iob_cpu_bridge_pkg:
  - state encoding (IDLE, BUSY)
  - localparams STRB_W=DATA_W/8 and LANE_W=log2(STRB_W)
  - strobe-generation function
- One sub-module, iob_cpu_bridge_wdog: timeout counter with clear/enable/terminal-count output. It is omitted via generate when TIMEOUT_W=0.

Test Plan:
- Read, DATA_W=32: cmd addr 0x104, size 2 → iob_valid next cycle, iob_wstrb=0x0, iob_addr=0x104. Memory returns 0xDEADBEEF with iob_ready after 3 cycles → rsp_valid for 1 cycle, rsp_data=0xDEADBEEF, rsp_error=0.
- Byte write, DATA_W=32: addr 0x203, size 0, WR_RSP=0 → iob_wstrb=0x8; no rsp_valid on completion. Repeat with WR_RSP=1 → exactly one rsp_valid.
- Halfword write, DATA_W=64: addr 0x6, size 1 → iob_wstrb=0xC0. Size 3 at addr 0 → iob_wstrb=0xFF.
- Back-to-back: hold cmd_valid with 4 reads, iob_ready after 1 cycle each → iob_valid never drops between transactions, 4 rsp_valid pulses, addresses in order.
- Timeout, TIMEOUT_W=4: iob_ready held low → after 15 BUSY cycles iob_valid=0, rsp_valid=1 with rsp_error=1. A following command completes normally.
- Remap with IOB_CPU_BRIDGE_EXTMEM_REMAP_EN: boot=1, addr 0x00000010 → iob_addr 0x00000010. boot=0 → iob_addr 0x80000010. Assert rst mid-BUSY → all outputs 0, no response.
